// File: rtl/traffic_controller_n.sv
// N-phase traffic signal controller: demand-driven round-robin with green extension.
// Define TRAFFIC_PREEMPT_EN to add the emergency pre-emption inputs (preempt, preempt_phase).
module traffic_controller_n #(
    parameter int unsigned NUM_PHASES       = 4,
    parameter int unsigned GREEN_CYCLES     = 8,
    parameter int unsigned MAX_GREEN_CYCLES = 16,
    parameter int unsigned YELLOW_CYCLES    = 3,
    parameter int unsigned ALLRED_CYCLES    = 2,
    parameter int unsigned TIMER_W          = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PHASES-1:0]           sensor,
`ifdef TRAFFIC_PREEMPT_EN
    input  logic                            preempt,
    input  logic [$clog2(NUM_PHASES)-1:0]   preempt_phase,
`endif
    output logic [3*NUM_PHASES-1:0]         leds,
    output logic [$clog2(NUM_PHASES)-1:0]   cur_phase,
    output logic [1:0]                      state
);

    localparam int unsigned PW = $clog2(NUM_PHASES);
    localparam logic [TIMER_W-1:0] T_ONE    = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] T_GREEN  = TIMER_W'(GREEN_CYCLES);
    localparam logic [TIMER_W-1:0] T_MAX    = TIMER_W'(MAX_GREEN_CYCLES);
    localparam logic [TIMER_W-1:0] T_YELLOW = TIMER_W'(YELLOW_CYCLES);
    localparam logic [TIMER_W-1:0] T_ALLRED = TIMER_W'(ALLRED_CYCLES);

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'b00,
        ST_GREEN   = 2'b01,
        ST_YELLOW  = 2'b10
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nx;
    logic [PW-1:0]           r_cur;
    logic [PW-1:0]           w_cur_nx;
    logic [TIMER_W-1:0]      r_timer;
    logic [TIMER_W-1:0]      w_timer_nx;
    logic [NUM_PHASES-1:0]   r_demand;
    logic [NUM_PHASES-1:0]   w_demand_nx;
    logic [3*NUM_PHASES-1:0] r_leds;
    logic [3*NUM_PHASES-1:0] w_leds_nx;

    logic [NUM_PHASES-1:0]   w_cur_mask;
    logic [NUM_PHASES-1:0]   w_req;
    logic [NUM_PHASES-1:0]   w_other;
    logic [NUM_PHASES-1:0]   w_latch_mask;
    logic [PW-1:0]           w_rr_pick;
    logic [PW-1:0]           w_idx;
    logic                    w_found;
    logic                    w_pre_valid;
    logic                    w_pre_hold;
    logic [PW-1:0]           w_pre_phase;

`ifdef TRAFFIC_PREEMPT_EN
    assign w_pre_valid = preempt && (32'(preempt_phase) < NUM_PHASES);
    assign w_pre_phase = preempt_phase;
`else
    assign w_pre_valid = 1'b0;
    assign w_pre_phase = '0;
`endif

    // Requests seen this clock include the live sensor, so a one-clock pulse counts immediately.
    always_comb begin
        w_cur_mask        = '0;
        w_cur_mask[r_cur] = 1'b1;
        w_req             = r_demand | sensor;
        w_other           = w_req & ~w_cur_mask;
        w_rr_pick         = PW'((32'(r_cur) + 32'd1) % NUM_PHASES);
        w_found           = 1'b0;
        w_idx             = '0;
        for (int unsigned k = 1; k <= NUM_PHASES; k++) begin
            w_idx = PW'((32'(r_cur) + k) % NUM_PHASES);
            if (!w_found && w_req[w_idx]) begin
                w_found   = 1'b1;
                w_rr_pick = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cur_nx   = r_cur;
        w_timer_nx = r_timer;
        w_pre_hold = w_pre_valid && (w_pre_phase == r_cur);
        unique case (r_state)
            ST_ALL_RED: begin
                if (r_timer <= T_ONE) begin
                    w_state_nx = ST_GREEN;
                    w_cur_nx   = w_pre_valid ? w_pre_phase : w_rr_pick;
                    w_timer_nx = T_ONE;
                end else begin
                    w_timer_nx = r_timer - T_ONE;
                end
            end
            ST_GREEN: begin
                // In green the timer counts elapsed clocks; a pre-emption hold restarts normal timing.
                if (w_pre_valid && !w_pre_hold) begin
                    w_state_nx = ST_YELLOW;
                    w_timer_nx = T_YELLOW;
                end else if (w_pre_hold) begin
                    w_timer_nx = T_ONE;
                end else if ((r_timer >= T_MAX) ||
                             ((r_timer >= T_GREEN) && ((|w_other) || !sensor[r_cur]))) begin
                    w_state_nx = ST_YELLOW;
                    w_timer_nx = T_YELLOW;
                end else begin
                    w_timer_nx = r_timer + T_ONE;
                end
            end
            ST_YELLOW: begin
                if (r_timer <= T_ONE) begin
                    w_state_nx = ST_ALL_RED;
                    w_timer_nx = T_ALLRED;
                end else begin
                    w_timer_nx = r_timer - T_ONE;
                end
            end
            default: begin
                w_state_nx = ST_ALL_RED;
                w_timer_nx = T_ALLRED;
            end
        endcase
    end

    always_comb begin
        w_latch_mask = (r_state == ST_GREEN) ? ~w_cur_mask : '1;
        w_demand_nx  = r_demand | (sensor & w_latch_mask);
        if ((w_state_nx == ST_GREEN) && (r_state != ST_GREEN)) begin
            w_demand_nx[w_cur_nx] = 1'b0;
        end
        w_leds_nx = '0;
        for (int unsigned i = 0; i < NUM_PHASES; i++) begin
            w_leds_nx[3*i +: 3] = 3'b100;
            if (PW'(i) == w_cur_nx) begin
                if (w_state_nx == ST_GREEN) begin
                    w_leds_nx[3*i +: 3] = 3'b001;
                end else if (w_state_nx == ST_YELLOW) begin
                    w_leds_nx[3*i +: 3] = 3'b010;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_ALL_RED;
            r_cur    <= PW'(NUM_PHASES - 1);
            r_timer  <= T_ALLRED;
            r_demand <= '0;
            r_leds   <= {NUM_PHASES{3'b100}};
        end else begin
            r_state  <= w_state_nx;
            r_cur    <= w_cur_nx;
            r_timer  <= w_timer_nx;
            r_demand <= w_demand_nx;
            r_leds   <= w_leds_nx;
        end
    end

    assign leds      = r_leds;
    assign cur_phase = r_cur;
    assign state     = r_state;

endmodule

// File: doc/traffic_controller_n.md
TRAFFIC_CONTROLLER_N -- requirements
Module: traffic_controller_n

Interface
REQ-001 SHALL have parameter NUM_PHASES, default 4: number of signal phases, legal range 2..8.
REQ-002 SHALL have parameter GREEN_CYCLES, default 8: base green duration in clocks.
REQ-003 SHALL have parameter MAX_GREEN_CYCLES, default 16: green ceiling with extension; must be >= GREEN_CYCLES.
REQ-004 SHALL have parameter YELLOW_CYCLES, default 3: yellow duration in clocks.
REQ-005 SHALL have parameter ALLRED_CYCLES, default 2: all-red clearance duration in clocks.
REQ-006 SHALL have parameter TIMER_W, default 8: timer width; every duration parameter must fit in it.
REQ-007 SHALL have port clk, input, 1: the single clock; all logic rises on it.
REQ-008 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-009 SHALL have port sensor, input, NUM_PHASES: per-phase vehicle detector, active-high, synchronous to clk.
REQ-010 SHALL have port leds, output, 3*NUM_PHASES: phase i owns bits [3i+2:3i] = {red, yellow, green}.
REQ-011 SHALL have port cur_phase, output, ceil(log2 NUM_PHASES): index of the phase currently green, yellow, or last served.
REQ-012 SHALL have port state, output, 2: 00 ALL_RED, 01 GREEN, 10 YELLOW.

Function
REQ-013 SHALL register all outputs; every leds field SHALL be exactly one-hot.
REQ-014 SHALL run FSM ALL_RED -> GREEN -> YELLOW -> ALL_RED; only cur_phase may be non-red, and only in GREEN or YELLOW.
REQ-015 SHALL hold ALL_RED exactly ALLRED_CYCLES clocks and YELLOW exactly YELLOW_CYCLES clocks, using a down-counter reloaded on every state entry.
REQ-016 SHALL latch demand[i] when sensor[i] is high, except while phase i is GREEN; demand[i] SHALL clear on the clock phase i enters GREEN, and the clear SHALL win over a simultaneous set.
REQ-017 SHALL select the next phase on the last ALL_RED clock: the first phase with demand set, searching round-robin from cur_phase+1 and wrapping modulo NUM_PHASES; with no demand anywhere it SHALL take cur_phase+1 (fixed rotation).
REQ-018 SHALL end GREEN after GREEN_CYCLES when another phase has demand, or when no phase has demand and the own sensor is low.
REQ-019 SHALL extend GREEN one clock at a time while the own sensor is high and no other demand exists, capped at MAX_GREEN_CYCLES total.
REQ-020 SHALL end an extension on the clock after other demand appears, once GREEN_CYCLES has elapsed.
REQ-021 SHALL accept sensor pulses as short as one clock.

Reset
REQ-022 SHALL, while reset is low, force state=ALL_RED, leds all-red (every field 100), cur_phase=NUM_PHASES-1, demand=0, and timer loaded with ALLRED_CYCLES.
REQ-023 SHALL make the first green after reset release phase 0, absent other demand.
REQ-024 SHALL, on a mid-GREEN or mid-YELLOW reset, immediately show all-red with no yellow, and discard latched demand.

Configuration
REQ-025 SHALL use macro TRAFFIC_PREEMPT_EN; when defined it SHALL add input preempt (1 bit) and input preempt_phase (cur_phase width).
REQ-026 SHALL, with TRAFFIC_PREEMPT_EN defined and preempt high, move GREEN of any other phase to YELLOW the next clock; ALL_RED then goes to GREEN of preempt_phase.
REQ-027 SHALL hold that preempt_phase GREEN while preempt stays high, ignoring MAX_GREEN_CYCLES; on release it SHALL serve the normal green timing, then resume round-robin.
REQ-028 SHALL, with TRAFFIC_PREEMPT_EN undefined, have neither preempt port and keep behaviour identical to REQ-013..REQ-024.
REQ-029 SHALL treat a preempt_phase >= NUM_PHASES as ignored.

Verification (NUM_PHASES=4, defaults)
REQ-030 SHALL check: reset low 5 clks, release, no sensors -> 2 clk all-red, phase0 green 8, yellow 3, all-red 2, phase1 green; leds never non-one-hot.
REQ-031 SHALL check: sensor=0100 pulsed 1 clk during phase0 green -> after phase0 yellow/all-red, phase2 green (phase1 skipped); demand[2] clears on entry.
REQ-032 SHALL check: sensor[0] held high, no other demand -> phase0 green lasts 16 clks; sensor[3] raised at green clk 10 -> yellow starts clk 11.
REQ-033 SHALL check: sensor=1010 simultaneously while phase0 green -> phase1 served, then phase3.
REQ-034 SHALL check: reset asserted mid-yellow -> leds all-red the same cycle (asynchronous); after release, phase0 is served first.
REQ-035 SHALL check (TRAFFIC_PREEMPT_EN defined): preempt=1, preempt_phase=2 during phase0 green -> yellow next clk, all-red 2, phase2 green held 30 clks; release -> 8 more clks green, then phase3.
